lcd_bus_receiver: RTL and testbench

- HD44780-side receiver for the 16x2 LCD bus that the LCD writer drives (LCD_EN/LCD_RS/LCD_RW/LCD_DATA).
- Samples bus transactions on the falling edge of LCD_EN and decodes instructions and data writes.
- Keeps a 32-character shadow frame buffer: line 0 at indexes 0-15, line 1 at indexes 16-31.
- Used as a bus monitor and mirror, e.g. for a bench scoreboard or a second display path.

---
 rtl/lcd_bus_pkg.sv | 65 ++++++
 rtl/lcd_bus_receiver_sync.sv | 53 +++++
 rtl/lcd_bus_receiver.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
// -----------------------------------------------------------------------------
// lcd_bus_pkg
// Shared constants, state encoding and helpers for the HD44780-side LCD bus
// receiver: instruction opcode prefixes, DDRAM line geometry, the space fill
// character and the DDRAM address-counter step rule.
// -----------------------------------------------------------------------------
package lcd_bus_pkg;

    // Instruction prefixes; the highest set bit of the byte selects the command.
    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_ENTRY  = 8'h04;
    localparam logic [7:0] CMD_DISP   = 8'h08;
    localparam logic [7:0] CMD_SETDD  = 8'h80;

    // DDRAM geometry of a 16x2 panel.
    localparam logic [6:0] LINE0_LAST = 7'h0F;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE1_LAST = 7'h4F;
    localparam logic [6:0] ADDR_ZERO  = 7'h00;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam int         FB_DEPTH   = 32;
    localparam int         FB_IDX_W   = 5;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    // Next DDRAM address after a data write; wraps between the two visible
    // line windows instead of walking through the invisible 0x10-0x3F gap.
    function automatic logic [6:0] addr_step(input logic [6:0] addr, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (addr == LINE0_LAST) begin
                nxt = LINE1_BASE;
            end else if (addr == LINE1_LAST) begin
                nxt = ADDR_ZERO;
            end else begin
                nxt = addr + 7'd1;
            end
        end else begin
            if (addr == ADDR_ZERO) begin
                nxt = LINE1_LAST;
            end else if (addr == LINE1_BASE) begin
                nxt = LINE0_LAST;
            end else begin
                nxt = addr - 7'd1;
            end
        end
        return nxt;
    endfunction

    // True when the address falls into 0x00-0x0F or 0x40-0x4F.
    function automatic logic addr_visible(input logic [6:0] addr);
        return (addr[5:4] == 2'b00);
    endfunction

    // Frame-buffer index of a visible address: line bit plus column.
    function automatic logic [FB_IDX_W-1:0] addr_to_idx(input logic [6:0] addr);
        return {addr[6], addr[3:0]};
    endfunction

endpackage

// File: rtl/lcd_bus_receiver_sync.sv
// -----------------------------------------------------------------------------
// lcd_bus_sync
// Multi-stage synchronizer for the asynchronous LCD bus plus falling-edge
// detection on the synchronized enable. EN/RS/RW/DATA travel through the same
// flop chain so the bus fields stay aligned with the detected edge.
//   clk_i, rst_i          : system clock, synchronous active-high reset
//   en_i/rs_i/rw_i/data_i : raw LCD bus inputs
//   fall_pulse            : one-cycle pulse when synced EN goes 1 -> 0
//   rs/rw/data            : bus fields at the synced stage
// -----------------------------------------------------------------------------
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [7:0] data_i,
    output logic       fall_pulse,
    output logic       rs,
    output logic       rw,
    output logic [7:0] data
);

    localparam int BUS_W = 11;
    localparam int LAST  = SYNC_STAGES - 1;

    logic [BUS_W-1:0] stage_q [SYNC_STAGES];
    logic             en_prev_q;

    // Synchronizer chain and delayed copy of synced EN for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= {BUS_W{1'b0}};
            end
            en_prev_q <= 1'b0;
        end else begin
            stage_q[0] <= {en_i, rs_i, rw_i, data_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            en_prev_q <= stage_q[LAST][10];
        end
    end

    assign fall_pulse = en_prev_q & ~stage_q[LAST][10];
    assign rs         = stage_q[LAST][9];
    assign rw         = stage_q[LAST][8];
    assign data       = stage_q[LAST][7:0];

endmodule

// File: rtl/lcd_bus_receiver.sv
// -----------------------------------------------------------------------------
// lcd_bus_receiver
// HD44780-side receiver: samples LCD bus transactions on the falling edge of
// EN, decodes instructions and data writes, and mirrors the 16x2 display into
// a 32-entry shadow frame buffer (line 0 -> 0..15, line 1 -> 16..31).
//   iCLK, iRST      : system clock, synchronous active-high reset
//   iLCD_*          : LCD bus (input only, asynchronous)
//   iRD_IDX/oRD_CHAR: frame-buffer read port, 1-cycle registered latency
//   oADDR           : DDRAM address counter
//   oDISP_ON        : D bit of the last display-control instruction
//   oWR_STB/oCMD_STB: one-cycle pulses per accepted data write / instruction
//   oCMD            : last accepted instruction byte
//   oBUSY           : space-fill sweep in progress
//   oOVR            : sticky: transaction dropped while busy, or read seen
// -----------------------------------------------------------------------------
module lcd_bus_receiver
    import lcd_bus_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iLCD_EN,
    input  logic       iLCD_RS,
    input  logic       iLCD_RW,
    input  logic [7:0] iLCD_DATA,
    input  logic [4:0] iRD_IDX,
    output logic [7:0] oRD_CHAR,
    output logic [6:0] oADDR,
    output logic       oDISP_ON,
    output logic       oWR_STB,
    output logic       oCMD_STB,
    output logic [7:0] oCMD,
    output logic       oBUSY,
    output logic       oOVR
);

    localparam state_e     RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    localparam logic [4:0] SWEEP_LAST  = 5'(FB_DEPTH - 1);

    logic       fall_s;
    logic       rs_s;
    logic       rw_s;
    logic [7:0] data_s;

    lcd_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i     (iCLK),
        .rst_i     (iRST),
        .en_i      (iLCD_EN),
        .rs_i      (iLCD_RS),
        .rw_i      (iLCD_RW),
        .data_i    (iLCD_DATA),
        .fall_pulse(fall_s),
        .rs        (rs_s),
        .rw        (rw_s),
        .data      (data_s)
    );

    state_e     state_q, state_d;
    logic [4:0] sweep_q, sweep_d;
    logic [6:0] addr_q, addr_d;
    logic       disp_q, disp_d;
    logic       dir_q, dir_d;
    logic       wr_stb_q, wr_stb_d;
    logic       cmd_stb_q, cmd_stb_d;
    logic [7:0] cmd_q, cmd_d;
    logic       ovr_q, ovr_d;
    logic [7:0] rd_char_q;
    logic [7:0] fb_q [FB_DEPTH];

    logic       clear_cmd_s;
    logic       fb_we_s;
    logic [4:0] fb_widx_s;
    logic [7:0] fb_wdata_s;

    // Clear instruction accepted this cycle (only possible while idle).
    always_comb begin
        clear_cmd_s = fall_s && (state_q == S_IDLE) && !rw_s && !rs_s
                      && (data_s == CMD_CLEAR);
    end

    // FSM state register and sweep index; reset restarts any sweep at 0.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= RESET_STATE;
            sweep_q <= 5'd0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // FSM next-state: sweep 32 entries, then return to decoding.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            S_CLEAR: begin
                sweep_d = sweep_q + 5'd1;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_IDLE: begin
                sweep_d = 5'd0;
                if (clear_cmd_s) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = RESET_STATE;
                sweep_d = 5'd0;
            end
        endcase
    end

    // FSM outputs: buffer write port, register next values and strobes.
    always_comb begin
        addr_d     = addr_q;
        disp_d     = disp_q;
        dir_d      = dir_q;
        cmd_d      = cmd_q;
        ovr_d      = ovr_q;
        wr_stb_d   = 1'b0;
        cmd_stb_d  = 1'b0;
        fb_we_s    = 1'b0;
        fb_widx_s  = 5'd0;
        fb_wdata_s = 8'h00;
        case (state_q)
            S_CLEAR: begin
                fb_we_s    = 1'b1;
                fb_widx_s  = sweep_q;
                fb_wdata_s = CHAR_SPACE;
                if (fall_s) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
            end
            S_IDLE: begin
                if (!fall_s) begin
                    ovr_d = ovr_q;
                end else if (rw_s) begin
                    ovr_d = 1'b1;
                end else if (rs_s) begin
                    wr_stb_d = 1'b1;
                    // Bytes aimed at the invisible DDRAM gap are dropped.
                    if (addr_visible(addr_q)) begin
                        fb_we_s    = 1'b1;
                        fb_widx_s  = addr_to_idx(addr_q);
                        fb_wdata_s = data_s;
                    end else begin
                        fb_we_s = 1'b0;
                    end
                    addr_d = addr_step(addr_q, dir_q);
                end else begin
                    cmd_stb_d = 1'b1;
                    cmd_d     = data_s;
                    if ((data_s & CMD_SETDD) != 8'h00) begin
                        addr_d = data_s[6:0];
                    end else if (data_s[6:4] != 3'b000) begin
                        // CGRAM address, function set, cursor shift: no effect.
                        addr_d = addr_q;
                    end else if ((data_s & CMD_DISP) != 8'h00) begin
                        disp_d = data_s[2];
                    end else if ((data_s & CMD_ENTRY) != 8'h00) begin
                        dir_d = data_s[1];
                    end else if ((data_s & CMD_HOME) != 8'h00) begin
                        addr_d = ADDR_ZERO;
                    end else if ((data_s & CMD_CLEAR) != 8'h00) begin
                        addr_d = ADDR_ZERO;
                        dir_d  = 1'b1;
                    end else begin
                        addr_d = addr_q;
                    end
                end
            end
            default: begin
                ovr_d = ovr_q;
            end
        endcase
    end

    // Output registers and registered read port.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            addr_q    <= 7'h00;
            disp_q    <= 1'b0;
            dir_q     <= 1'b1;
            wr_stb_q  <= 1'b0;
            cmd_stb_q <= 1'b0;
            cmd_q     <= 8'h00;
            ovr_q     <= 1'b0;
            rd_char_q <= 8'h00;
        end else begin
            addr_q    <= addr_d;
            disp_q    <= disp_d;
            dir_q     <= dir_d;
            wr_stb_q  <= wr_stb_d;
            cmd_stb_q <= cmd_stb_d;
            cmd_q     <= cmd_d;
            ovr_q     <= ovr_d;
            rd_char_q <= fb_q[iRD_IDX];
        end
    end

    // Frame-buffer storage; contents survive reset and are rewritten by a sweep.
    always_ff @(posedge iCLK) begin
        if (fb_we_s) begin
            fb_q[fb_widx_s] <= fb_wdata_s;
        end
    end

    assign oRD_CHAR = rd_char_q;
    assign oADDR    = addr_q;
    assign oDISP_ON = disp_q;
    assign oWR_STB  = wr_stb_q;
    assign oCMD_STB = cmd_stb_q;
    assign oCMD     = cmd_q;
    assign oBUSY    = (state_q == S_CLEAR);
    assign oOVR     = ovr_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_receiver
// Self-checking bench: directed writer sequences plus randomized transactions,
// compared every cycle against a behavioural model of the display controller.
// -----------------------------------------------------------------------------
module tb_lcd_bus_receiver;

    localparam int SYNC_STAGES    = 2;
    localparam bit CLEAR_ON_RESET = 1'b1;
    localparam int LAT            = SYNC_STAGES + 1;

    logic       iCLK      = 1'b0;
    logic       iRST      = 1'b1;
    logic       iLCD_EN   = 1'b0;
    logic       iLCD_RS   = 1'b0;
    logic       iLCD_RW   = 1'b0;
    logic [7:0] iLCD_DATA = 8'h00;
    logic [4:0] iRD_IDX   = 5'd0;
    logic [7:0] oRD_CHAR;
    logic [6:0] oADDR;
    logic       oDISP_ON, oWR_STB, oCMD_STB, oBUSY, oOVR;
    logic [7:0] oCMD;

    lcd_bus_receiver #(
        .SYNC_STAGES   (SYNC_STAGES),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iLCD_EN  (iLCD_EN),
        .iLCD_RS  (iLCD_RS),
        .iLCD_RW  (iLCD_RW),
        .iLCD_DATA(iLCD_DATA),
        .iRD_IDX  (iRD_IDX),
        .oRD_CHAR (oRD_CHAR),
        .oADDR    (oADDR),
        .oDISP_ON (oDISP_ON),
        .oWR_STB  (oWR_STB),
        .oCMD_STB (oCMD_STB),
        .oCMD     (oCMD),
        .oBUSY    (oBUSY),
        .oOVR     (oOVR)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- edge bookkeeping ----------------
    int         cyc = 0;
    bit         rst_e;
    logic [4:0] idx_e;
    bit         rand_idx   = 1'b1;
    logic [4:0] forced_idx = 5'd0;

    always @(posedge iCLK) begin
        cyc++;
        rst_e = iRST;
        idx_e = iRD_IDX;
    end

    always @(posedge iCLK) begin
        #2;
        iRD_IDX = rand_idx ? 5'($urandom_range(0, 31)) : forced_idx;
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int  due;
        bit  rs;
        bit  rw;
        int  d;
    } txn_t;
    txn_t q[$];

    int m_addr = 0, m_dir = 1, m_disp = 0, m_cmd = 0, m_ovr = 0;
    int m_wr = 0, m_cs = 0, m_sweep = 0, m_rd = 0;
    bit m_rd_known = 1'b0;
    int m_fb[32];
    bit m_known[32];
    int busy_cnt = 0;
    int wr_cnt   = 0;

    function automatic int step(input int a, input int inc);
        if (inc != 0) return (a == 15) ? 64 : (a == 79) ? 0 : (a + 1) % 128;
        else          return (a == 0) ? 79 : (a == 64) ? 15 : (a + 127) % 128;
    endfunction

    task automatic apply(input txn_t t);
        if (t.rw) begin
            m_ovr = 1;
        end else if (t.rs) begin
            m_wr = 1;
            if (m_addr <= 15) begin
                m_fb[m_addr] = t.d; m_known[m_addr] = 1'b1;
            end else if (m_addr >= 64 && m_addr <= 79) begin
                m_fb[m_addr - 48] = t.d; m_known[m_addr - 48] = 1'b1;
            end
            m_addr = step(m_addr, m_dir);
        end else begin
            m_cs  = 1;
            m_cmd = t.d;
            if (t.d >= 128)     m_addr = t.d - 128;
            else if (t.d >= 16) m_addr = m_addr;
            else if (t.d >= 8)  m_disp = (t.d >> 2) & 1;
            else if (t.d >= 4)  m_dir  = (t.d >> 1) & 1;
            else if (t.d >= 2)  m_addr = 0;
            else if (t.d == 1) begin m_addr = 0; m_dir = 1; m_sweep = 32; end
        end
    endtask

    task automatic advance();
        txn_t t;
        bit   have;
        have = 1'b0;
        m_wr = 0;
        m_cs = 0;
        if (rst_e) begin
            m_addr = 0; m_dir = 1; m_disp = 0; m_cmd = 0; m_ovr = 0;
            m_sweep = CLEAR_ON_RESET ? 32 : 0;
            m_rd = 0; m_rd_known = 1'b1;
            q.delete();
        end else begin
            m_rd = m_fb[idx_e];
            m_rd_known = m_known[idx_e];
            if (q.size() > 0 && q[0].due == cyc) begin
                t = q.pop_front();
                have = 1'b1;
            end
            if (m_sweep > 0) begin
                m_fb[32 - m_sweep] = 8'h20;
                m_known[32 - m_sweep] = 1'b1;
                m_sweep--;
                if (have) m_ovr = 1;
            end else if (have) begin
                apply(t);
            end
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge iCLK) begin
        if (cyc > 0) begin
            advance();
            chk("addr",    oADDR,    m_addr);
            chk("disp_on", oDISP_ON, m_disp);
            chk("wr_stb",  oWR_STB,  m_wr);
            chk("cmd_stb", oCMD_STB, m_cs);
            chk("cmd",     oCMD,     m_cmd);
            chk("busy",    oBUSY,    (m_sweep > 0) ? 1 : 0);
            chk("ovr",     oOVR,     m_ovr);
            if (m_rd_known) chk("rd_char", oRD_CHAR, m_rd);
            if (!iRST && oBUSY) busy_cnt++;
            if (oWR_STB) wr_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit rs, input bit rw, input int d);
        txn_t t;
        @(posedge iCLK); #2;
        iLCD_RS = rs; iLCD_RW = rw; iLCD_DATA = 8'(d); iLCD_EN = 1'b1;
        repeat (3) @(posedge iCLK);
        #2;
        iLCD_EN = 1'b0;
        t.due = cyc + LAT; t.rs = rs; t.rw = rw; t.d = d & 255;
        q.push_back(t);
        repeat (4) @(posedge iCLK);
    endtask

    task automatic read_chk(input int i, input int exp, input string name);
        rand_idx   = 1'b0;
        forced_idx = 5'(i);
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        chk($sformatf("%s[%0d]", name, i), oRD_CHAR, exp);
    endtask

    task automatic do_reset(input int edges);
        @(posedge iCLK); #2;
        iRST = 1'b1;
        repeat (edges) @(posedge iCLK);
        #2;
        iRST = 1'b0;
        busy_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        string s;
        txn_t  t;
        int    c0, lat;
        bit    found;

        // Reset and power-on space fill.
        do_reset(3);
        repeat (40) @(posedge iCLK);
        chk("busy_cycles_after_reset", busy_cnt, 32);
        for (int i = 0; i < 32; i++) read_chk(i, 8'h20, "space_fill");
        chk("addr_after_reset", oADDR, 0);
        chk("ovr_after_reset", oOVR, 0);

        // Writer init sequence then "Primeira".
        send(1'b0, 1'b0, 8'h38);
        send(1'b0, 1'b0, 8'h0C);
        send(1'b0, 1'b0, 8'h06);
        send(1'b0, 1'b0, 8'h01);
        repeat (40) @(posedge iCLK);
        wr_cnt = 0;
        s = "Primeira";
        for (int i = 0; i < 8; i++) send(1'b1, 1'b0, int'(s[i]));
        @(negedge iCLK);
        chk("disp_on_after_init", oDISP_ON, 1);
        chk("wr_pulses_primeira", wr_cnt, 8);
        chk("addr_after_primeira", oADDR, 8'h08);
        chk("model_fb0", m_fb[0], 8'h50);
        for (int i = 0; i < 8; i++) read_chk(i, int'(s[i]), "primeira");

        // Line wrap 0x0F -> 0x40.
        send(1'b0, 1'b0, 8'h8F);
        send(1'b1, 1'b0, 8'h41);
        send(1'b1, 1'b0, 8'h42);
        @(negedge iCLK);
        chk("addr_after_wrap", oADDR, 8'h41);
        chk("model_fb15", m_fb[15], 8'h41);
        read_chk(15, 8'h41, "wrap");
        read_chk(16, 8'h42, "wrap");

        // Decrement mode across 0x40 -> 0x0F.
        send(1'b0, 1'b0, 8'h04);
        send(1'b0, 1'b0, 8'hC0);
        send(1'b1, 1'b0, 8'h78);
        @(negedge iCLK);
        chk("addr_after_decrement", oADDR, 8'h0F);
        read_chk(16, 8'h78, "decrement");

        // Transactions during a sweep are dropped; RW=1 is flagged.
        wr_cnt = 0;
        send(1'b0, 1'b0, 8'h01);
        send(1'b1, 1'b0, 8'h5A);
        @(negedge iCLK);
        chk("ovr_after_drop", oOVR, 1);
        chk("busy_during_drop", oBUSY, 1);
        send(1'b0, 1'b1, 8'h55);
        repeat (40) @(posedge iCLK);
        chk("wr_pulses_during_sweep", wr_cnt, 0);
        chk("addr_after_clear", oADDR, 0);
        for (int i = 0; i < 32; i++) read_chk(i, 8'h20, "after_sweep");
        rand_idx = 1'b1;

        // Latency: EN falls mid-cycle; the sampling edge counts as the first.
        @(posedge iCLK); #2;
        iLCD_RS = 1'b1; iLCD_RW = 1'b0; iLCD_DATA = 8'h4C; iLCD_EN = 1'b1;
        repeat (3) @(posedge iCLK);
        #7;
        iLCD_EN = 1'b0;
        c0 = cyc;
        t.due = cyc + LAT; t.rs = 1'b1; t.rw = 1'b0; t.d = 8'h4C;
        q.push_back(t);
        found = 1'b0;
        lat = -1;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge iCLK);
            if (oWR_STB) begin found = 1'b1; lat = cyc - c0; end
        end
        chk("wr_stb_latency", lat, 3);
        repeat (3) @(posedge iCLK);

        // Reset mid-sweep restarts the full 32-cycle sweep.
        send(1'b0, 1'b0, 8'h01);
        repeat (10) @(posedge iCLK);
        do_reset(2);
        repeat (40) @(posedge iCLK);
        chk("busy_cycles_after_midsweep_reset", busy_cnt, 32);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 120; n++) begin
            bit rs, rw;
            int d;
            rs = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 9) == 0);
            d  = $urandom_range(0, 255);
            send(rs, rw, d);
        end
        repeat (40) @(posedge iCLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
